aes_round_sched: RTL

//  Round scheduler/arbiter for the shared binary-encoded AES round datapath.

---
 rtl/aes_round_sched.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/aes_round_sched.sv
// Round scheduler/arbiter for a shared AES round datapath: round-robin grant between two
// requesters, round sequencing, and a complemented shadow state register that traps faults.
module aes_round_sched #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       key_ready,
  input  logic       data_stable,
  output logic [1:0] grant,
  output logic       busy,
  output logic       load_state,
  output logic       round_en,
  output logic [3:0] round_index,
  output logic [1:0] round_type_sel,
  output logic       done,
  output logic       done_id,
  output logic       fsm_err
);

  localparam logic [2:0] S_IDLE     = 3'b000;
  localparam logic [2:0] S_WAIT_KEY = 3'b001;
  localparam logic [2:0] S_LOAD     = 3'b010;
  localparam logic [2:0] S_ROUND    = 3'b011;
  localparam logic [2:0] S_FINAL    = 3'b100;
  localparam logic [2:0] S_DONE     = 3'b101;
  localparam logic [2:0] S_ERR      = 3'b111;

  localparam logic [3:0] LAST_MID_IDX = 4'(NUM_ROUNDS - 1);
  localparam logic [3:0] FINAL_IDX    = 4'(NUM_ROUNDS);

  localparam logic [1:0] SEL_ARK   = 2'b00;
  localparam logic [1:0] SEL_MID   = 2'b01;
  localparam logic [1:0] SEL_FINAL = 2'b10;
  localparam logic [1:0] SEL_IDLE  = 2'b11;

  // Handshake: req is a level held by the requester until its done pulse; grant is the
  // registered one-hot owner. A request is only arbitrated while the FSM sits in IDLE.

  logic [2:0] state_q, state_d;
  logic [2:0] shadow_q, shadow_d;
  logic       owner_q, owner_d;
  logic       last_served_q, last_served_d;
  logic [3:0] idx_q, idx_d;
  logic [1:0] grant_q, grant_d;
  logic       busy_q, busy_d;
  logic       load_state_q, load_state_d;
  logic       round_en_q, round_en_d;
  logic [1:0] sel_q, sel_d;
  logic       done_q, done_d;
  logic       done_id_q, done_id_d;
  logic       fsm_err_q, fsm_err_d;
  logic       integrity_err;
  logic       job_active;

  always_comb begin
    integrity_err = (state_q != ~shadow_q) || (state_q == 3'b110);
    state_d       = state_q;
    owner_d       = owner_q;
    last_served_d = last_served_q;
    idx_d         = idx_q;
    if (integrity_err) begin
      state_d = S_ERR;
      idx_d   = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          idx_d = 4'd0;
          if (req != 2'b00) begin
            state_d = S_WAIT_KEY;
            case (req)
              2'b01:   owner_d = 1'b0;
              2'b10:   owner_d = 1'b1;
              default: owner_d = ~last_served_q;
            endcase
          end
        end
        S_WAIT_KEY: begin
          // An owner withdrawing before LOAD aborts cleanly; fairness state is left alone.
          if (!req[owner_q]) begin
            state_d = S_IDLE;
          end else if (key_ready && data_stable) begin
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          state_d = S_ROUND;
          idx_d   = 4'd1;
        end
        S_ROUND: begin
          if (key_ready) begin
            idx_d = idx_q + 4'd1;
            if (idx_q == LAST_MID_IDX) begin
              state_d = S_FINAL;
            end
          end
        end
        S_FINAL: begin
          idx_d = FINAL_IDX;
          if (key_ready) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          last_served_d = owner_q;
          state_d       = S_IDLE;
          idx_d         = 4'd0;
        end
        S_ERR: begin
          state_d = S_ERR;
          idx_d   = 4'd0;
        end
        default: begin
          state_d = S_ERR;
          idx_d   = 4'd0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    shadow_d     = ~state_d;
    job_active   = (state_d == S_WAIT_KEY) || (state_d == S_LOAD) || (state_d == S_ROUND) ||
                   (state_d == S_FINAL) || (state_d == S_DONE);
    busy_d       = job_active;
    grant_d      = 2'b00;
    if (job_active) begin
      grant_d = owner_d ? 2'b10 : 2'b01;
    end
    load_state_d = (state_d == S_LOAD);
    round_en_d   = (state_d == S_LOAD) ||
                   (((state_d == S_ROUND) || (state_d == S_FINAL)) && key_ready);
    case (state_d)
      S_LOAD:  sel_d = SEL_ARK;
      S_ROUND: sel_d = SEL_MID;
      S_FINAL: sel_d = SEL_FINAL;
      S_DONE:  sel_d = SEL_FINAL;
      default: sel_d = SEL_IDLE;
    endcase
    done_d    = (state_d == S_DONE);
    done_id_d = (state_d == S_DONE) ? owner_q : 1'b0;
    fsm_err_d = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      shadow_q      <= ~S_IDLE;
      owner_q       <= 1'b0;
      last_served_q <= 1'b1;
      idx_q         <= 4'd0;
      grant_q       <= 2'b00;
      busy_q        <= 1'b0;
      load_state_q  <= 1'b0;
      round_en_q    <= 1'b0;
      sel_q         <= SEL_IDLE;
      done_q        <= 1'b0;
      done_id_q     <= 1'b0;
      fsm_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      owner_q       <= owner_d;
      last_served_q <= last_served_d;
      idx_q         <= idx_d;
      grant_q       <= grant_d;
      busy_q        <= busy_d;
      load_state_q  <= load_state_d;
      round_en_q    <= round_en_d;
      sel_q         <= sel_d;
      done_q        <= done_d;
      done_id_q     <= done_id_d;
      fsm_err_q     <= fsm_err_d;
    end
  end

  assign grant          = grant_q;
  assign busy           = busy_q;
  assign load_state     = load_state_q;
  assign round_en       = round_en_q;
  assign round_index    = idx_q;
  assign round_type_sel = sel_q;
  assign done           = done_q;
  assign done_id        = done_id_q;
  assign fsm_err        = fsm_err_q;

endmodule
